// File: rtl/soin_bpredictor_resolve_pkg.sv
// Shared types, meta field layout macros and counter helper for the predictor resolve slice.
// The `BP_META_* macros describe the 24-bit prediction metadata word carried from fetch.
`ifndef SOIN_HEADER_DEFS
`define SOIN_HEADER_DEFS
`define BP_META_WIDTH 24
`define BP_META_INDEX 0
`define BP_META_DATA  8
`define BP_META_BE    16
`define BP_META_RAS   20
`endif

package soin_bpredictor_resolve_pkg;

   localparam int META_W = `BP_META_WIDTH;

   typedef struct packed {
      logic [31:0]       pc;
      logic              p_dir;
      logic [31:0]       p_target;
      logic [META_W-1:0] meta;
   } bp_entry_t;

   // Saturating update of one 2-bit slot inside a packed counter byte.
   function automatic logic [7:0] bump_cnt(input logic [7:0] cnt_byte,
                                           input logic [1:0] slot,
                                           input logic       taken,
                                           input logic [1:0] cnt_max);
      logic [7:0] res;
      logic [2:0] sh;
      logic [1:0] cur;
      res = cnt_byte;
      sh  = {slot, 1'b0};
      cur = cnt_byte[sh +: 2];
      if (taken) begin
         if (cur < cnt_max) cur = cur + 2'd1;
         else               cur = cnt_max;
      end else begin
         if (cur != 2'd0)   cur = cur - 2'd1;
         else               cur = 2'd0;
      end
      res[sh +: 2] = cur;
      return res;
   endfunction

endpackage

// File: rtl/soin_bp_meta_fifo.sv
// In-flight prediction FIFO: push/pop/flush with full/empty; flush has priority over push/pop.
module soin_bp_meta_fifo
#(
   parameter int DEPTH_L = 3,
   parameter int WIDTH   = 89
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 1 << DEPTH_L;

   logic [WIDTH-1:0]   mem_r [DEPTH];
   logic [DEPTH_L-1:0] wr_ptr_r;
   logic [DEPTH_L-1:0] rd_ptr_r;
   logic [DEPTH_L:0]   count_r;
   logic               do_push_s;
   logic               do_pop_s;

   assign full  = (count_r == DEPTH[DEPTH_L:0]);
   assign empty = (count_r == {(DEPTH_L+1){1'b0}});
   assign rdata = mem_r[rd_ptr_r];

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      do_pop_s  = pop & ~empty;
      do_push_s = push & ~flush & (~full | do_pop_s);
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= {DEPTH_L{1'b0}};
         rd_ptr_r <= {DEPTH_L{1'b0}};
         count_r  <= {(DEPTH_L+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (flush) begin
         wr_ptr_r <= {DEPTH_L{1'b0}};
         rd_ptr_r <= {DEPTH_L{1'b0}};
         count_r  <= {(DEPTH_L+1){1'b0}};
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + {{(DEPTH_L-1){1'b0}}, 1'b1};
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(DEPTH_L-1){1'b0}}, 1'b1};
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + {{DEPTH_L{1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{DEPTH_L{1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/soin_bpredictor_resolve.sv
// Execute-side branch resolution: compares stored predictions with outcomes, builds predictor
// updates and fetch redirects. Optional statistics counters are enabled by SOIN_BP_STATS_EN.
module soin_bpredictor_resolve
   import soin_bpredictor_resolve_pkg::*;
#(
   parameter int DEPTH_L = 3,
   parameter int CNT_MAX = 3
)
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      fetch_valid,
   input  logic [31:0]               fetch_PC,
   input  logic                      fetch_p_dir,
   input  logic [31:0]               fetch_p_target,
   input  logic [`BP_META_WIDTH-1:0] fetch_meta,
   output logic                      resolve_full,
   input  logic                      execute_valid,
   input  logic                      execute_is_branch,
   input  logic                      execute_dir,
   input  logic [31:0]               execute_target,
   output logic                      execute_bpredictor_update,
   output logic [31:0]               execute_bpredictor_PC,
   output logic [31:0]               execute_bpredictor_target,
   output logic                      execute_bpredictor_dir,
   output logic                      execute_bpredictor_miss,
   output logic [`BP_META_WIDTH-1:0] execute_bpredictor_meta,
   output logic                      execute_bpredictor_recover_ras,
   output logic                      fetch_redirect,
   output logic [31:0]               fetch_redirect_PC,
   output logic                      resolve_underflow,
   input  logic [31:0]               resolve_debug_sel,
   output logic [31:0]               resolve_debug
);

   localparam logic [0:0] ST_NORMAL = 1'b0;
   localparam logic [0:0] ST_FLUSH  = 1'b1;

   bp_entry_t   wr_entry_s;
   bp_entry_t   head_s;
   logic        fifo_full_s;
   logic        fifo_empty_s;
   logic        push_s;
   logic        pop_s;
   logic        miss_s;
   logic        issue_s;
   logic        flush_s;
   logic [7:0]  new_byte_s;
   logic [3:0]  be_s;
   logic [31:0] next_pc_s;
   logic [0:0]  state_r;
   logic        underflow_r;
   logic [3:0]  unused_meta_be_s;

   assign wr_entry_s       = '{pc: fetch_PC, p_dir: fetch_p_dir, p_target: fetch_p_target,
                               meta: fetch_meta};
   assign unused_meta_be_s = head_s.meta[`BP_META_BE +: 4];
   assign resolve_full      = fifo_full_s;
   assign resolve_underflow = underflow_r;

   soin_bp_meta_fifo #(
      .DEPTH_L (DEPTH_L),
      .WIDTH   ($bits(bp_entry_t))
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .pop   (pop_s),
      .flush (flush_s),
      .wdata (wr_entry_s),
      .rdata (head_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Compare head prediction with the resolved outcome and form the update fields.
   always_comb begin
      push_s     = fetch_valid & (state_r == ST_NORMAL);
      pop_s      = execute_valid & ~fifo_empty_s;
      miss_s     = (head_s.p_dir != execute_dir) |
                   (execute_dir & (head_s.p_target != execute_target));
      issue_s    = pop_s & (execute_is_branch | head_s.p_dir);
      flush_s    = issue_s & miss_s;
      new_byte_s = bump_cnt(head_s.meta[`BP_META_DATA +: 8], head_s.pc[3:2], execute_dir,
                            CNT_MAX[1:0]);
      be_s       = 4'b0001 << head_s.pc[5:4];
      next_pc_s  = execute_dir ? execute_target : (head_s.pc + 32'd4);
   end

   // Registered predictor update packet and fetch redirect; data fields hold between pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         execute_bpredictor_update      <= 1'b0;
         execute_bpredictor_PC          <= 32'd0;
         execute_bpredictor_target      <= 32'd0;
         execute_bpredictor_dir         <= 1'b0;
         execute_bpredictor_miss        <= 1'b0;
         execute_bpredictor_meta        <= {`BP_META_WIDTH{1'b0}};
         execute_bpredictor_recover_ras <= 1'b0;
         fetch_redirect                 <= 1'b0;
         fetch_redirect_PC              <= 32'd0;
      end else begin
         execute_bpredictor_update      <= issue_s;
         execute_bpredictor_recover_ras <= flush_s;
         fetch_redirect                 <= flush_s;
         if (issue_s) begin
            execute_bpredictor_PC     <= head_s.pc;
            execute_bpredictor_target <= execute_target;
            execute_bpredictor_dir    <= execute_dir;
            execute_bpredictor_miss   <= miss_s;
            execute_bpredictor_meta   <= {head_s.meta[`BP_META_RAS +: 4], be_s, new_byte_s,
                                          head_s.meta[`BP_META_INDEX +: 8]};
         end
         if (flush_s) begin
            fetch_redirect_PC <= next_pc_s;
         end
      end
   end

   // Flush state machine and sticky underflow flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_NORMAL;
         underflow_r <= 1'b0;
      end else begin
         case (state_r)
            ST_NORMAL: state_r <= flush_s ? ST_FLUSH : ST_NORMAL;
            ST_FLUSH:  state_r <= ST_NORMAL;
            default:   state_r <= ST_NORMAL;
         endcase
         if (execute_valid & fifo_empty_s) begin
            underflow_r <= 1'b1;
         end
      end
   end

`ifdef SOIN_BP_STATS_EN
   logic [31:0] upd_cnt_r;
   logic [31:0] miss_cnt_r;
   logic [31:0] debug_r;

   assign resolve_debug = debug_r;

   // Wrapping update/miss counters and registered debug read mux.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         upd_cnt_r  <= 32'd0;
         miss_cnt_r <= 32'd0;
         debug_r    <= 32'd0;
      end else begin
         if (issue_s) upd_cnt_r  <= upd_cnt_r + 32'd1;
         if (flush_s) miss_cnt_r <= miss_cnt_r + 32'd1;
         case (resolve_debug_sel)
            32'd0:   debug_r <= upd_cnt_r;
            32'd1:   debug_r <= miss_cnt_r;
            default: debug_r <= 32'd0;
         endcase
      end
   end
`else
   logic [31:0] unused_debug_sel_s;

   assign unused_debug_sel_s = resolve_debug_sel;
   assign resolve_debug      = 32'd0;
`endif

endmodule

// File: tb/tb_soin_bpredictor_resolve.sv
// Directed bench for soin_bpredictor_resolve with a queue-based reference model (default build).
`ifndef BP_META_WIDTH
`define BP_META_WIDTH 24
`endif

module tb_soin_bpredictor_resolve;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        fetch_valid = 1'b0;
   logic [31:0] fetch_PC = 32'd0;
   logic        fetch_p_dir = 1'b0;
   logic [31:0] fetch_p_target = 32'd0;
   logic [23:0] fetch_meta = 24'd0;
   logic        resolve_full;
   logic        execute_valid = 1'b0;
   logic        execute_is_branch = 1'b0;
   logic        execute_dir = 1'b0;
   logic [31:0] execute_target = 32'd0;
   logic        execute_bpredictor_update;
   logic [31:0] execute_bpredictor_PC;
   logic [31:0] execute_bpredictor_target;
   logic        execute_bpredictor_dir;
   logic        execute_bpredictor_miss;
   logic [23:0] execute_bpredictor_meta;
   logic        execute_bpredictor_recover_ras;
   logic        fetch_redirect;
   logic [31:0] fetch_redirect_PC;
   logic        resolve_underflow;
   logic [31:0] resolve_debug_sel = 32'd0;
   logic [31:0] resolve_debug;

   soin_bpredictor_resolve dut (
      .clk(clk), .reset(reset),
      .fetch_valid(fetch_valid), .fetch_PC(fetch_PC), .fetch_p_dir(fetch_p_dir),
      .fetch_p_target(fetch_p_target), .fetch_meta(fetch_meta), .resolve_full(resolve_full),
      .execute_valid(execute_valid), .execute_is_branch(execute_is_branch),
      .execute_dir(execute_dir), .execute_target(execute_target),
      .execute_bpredictor_update(execute_bpredictor_update),
      .execute_bpredictor_PC(execute_bpredictor_PC),
      .execute_bpredictor_target(execute_bpredictor_target),
      .execute_bpredictor_dir(execute_bpredictor_dir),
      .execute_bpredictor_miss(execute_bpredictor_miss),
      .execute_bpredictor_meta(execute_bpredictor_meta),
      .execute_bpredictor_recover_ras(execute_bpredictor_recover_ras),
      .fetch_redirect(fetch_redirect), .fetch_redirect_PC(fetch_redirect_PC),
      .resolve_underflow(resolve_underflow), .resolve_debug_sel(resolve_debug_sel),
      .resolve_debug(resolve_debug)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit check_en = 1'b0;

   typedef struct {
      logic [31:0] pc;
      logic        pdir;
      logic [31:0] ptgt;
      logic [23:0] meta;
   } ment_t;

   ment_t mq[$];
   bit    m_flushing;
   bit    m_underflow;

   // Expected outputs: nxt_* is what the next clock edge produces, exp_* what is visible now.
   logic        nxt_upd, nxt_dir, nxt_miss, nxt_redir, nxt_full;
   logic [31:0] nxt_pc, nxt_tgt, nxt_rpc;
   logic [23:0] nxt_meta;
   logic        exp_upd, exp_dir, exp_miss, exp_redir, exp_full, exp_unf;
   logic [31:0] exp_pc, exp_tgt, exp_rpc;
   logic [23:0] exp_meta;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_flushing = 1'b0; m_underflow = 1'b0;
      nxt_upd = 1'b0; nxt_dir = 1'b0; nxt_miss = 1'b0; nxt_redir = 1'b0; nxt_full = 1'b0;
      nxt_pc = 32'd0; nxt_tgt = 32'd0; nxt_rpc = 32'd0; nxt_meta = 24'd0;
      exp_upd = 1'b0; exp_dir = 1'b0; exp_miss = 1'b0; exp_redir = 1'b0; exp_full = 1'b0;
      exp_unf = 1'b0; exp_pc = 32'd0; exp_tgt = 32'd0; exp_rpc = 32'd0; exp_meta = 24'd0;
   endtask

   // Reference behaviour for one clock, from the current inputs and in-flight queue.
   task automatic model_step();
      int    n;
      bit    pop, push, miss;
      ment_t e;
      int    sh, cnt, byt;
      n    = mq.size();
      pop  = execute_valid && (n > 0);
      push = fetch_valid && !m_flushing && ((n < 8) || pop);
      nxt_upd = 1'b0;
      nxt_redir = 1'b0;
      if (execute_valid && n == 0) m_underflow = 1'b1;
      if (pop) begin
         e    = mq[0];
         miss = (e.pdir != execute_dir) || (execute_dir && (e.ptgt != execute_target));
         if (execute_is_branch || e.pdir) begin
            sh  = int'(e.pc[3:2]) * 2;
            byt = int'(e.meta[15:8]);
            cnt = (byt >> sh) % 4;
            if (execute_dir) cnt = (cnt < 3) ? cnt + 1 : 3;
            else             cnt = (cnt > 0) ? cnt - 1 : 0;
            byt = (byt & ~(3 << sh)) | (cnt << sh);
            nxt_upd  = 1'b1;
            nxt_pc   = e.pc;
            nxt_tgt  = execute_target;
            nxt_dir  = execute_dir;
            nxt_miss = miss;
            nxt_meta = {e.meta[23:20], 4'(1 << int'(e.pc[5:4])), 8'(byt), e.meta[7:0]};
            if (miss) begin
               nxt_redir = 1'b1;
               nxt_rpc   = execute_dir ? execute_target : e.pc + 32'd4;
            end
         end
      end
      if (nxt_redir) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (push) mq.push_back('{pc: fetch_PC, pdir: fetch_p_dir, ptgt: fetch_p_target,
                                  meta: fetch_meta});
      end
      nxt_full   = (mq.size() == 8);
      m_flushing = nxt_redir;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      exp_upd = nxt_upd; exp_pc = nxt_pc; exp_tgt = nxt_tgt; exp_dir = nxt_dir;
      exp_miss = nxt_miss; exp_meta = nxt_meta; exp_redir = nxt_redir; exp_rpc = nxt_rpc;
      exp_full = nxt_full; exp_unf = m_underflow;
      fetch_valid = 1'b0;
      execute_valid = 1'b0;
      execute_is_branch = 1'b0;
      execute_dir = 1'b0;
   endtask

   task automatic push_in(input logic [31:0] pc, input logic pd, input logic [31:0] pt,
                          input logic [23:0] meta);
      fetch_valid = 1'b1; fetch_PC = pc; fetch_p_dir = pd; fetch_p_target = pt;
      fetch_meta = meta;
   endtask

   task automatic exec_in(input logic br, input logic dir, input logic [31:0] tgt);
      execute_valid = 1'b1; execute_is_branch = br; execute_dir = dir; execute_target = tgt;
   endtask

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (check_en) begin
         chk("update", 32'(execute_bpredictor_update), 32'(exp_upd));
         chk("bp_pc", execute_bpredictor_PC, exp_pc);
         chk("bp_target", execute_bpredictor_target, exp_tgt);
         chk("bp_dir", 32'(execute_bpredictor_dir), 32'(exp_dir));
         chk("bp_miss", 32'(execute_bpredictor_miss), 32'(exp_miss));
         chk("bp_meta", 32'(execute_bpredictor_meta), 32'(exp_meta));
         chk("recover_ras", 32'(execute_bpredictor_recover_ras), 32'(exp_redir));
         chk("redirect", 32'(fetch_redirect), 32'(exp_redir));
         chk("redirect_pc", fetch_redirect_PC, exp_rpc);
         chk("full", 32'(resolve_full), 32'(exp_full));
         chk("underflow", 32'(resolve_underflow), 32'(exp_unf));
         chk("debug", resolve_debug, 32'd0);
      end
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_en = 1'b1;
      chk("rst_update", 32'(execute_bpredictor_update), 32'd0);
      chk("rst_redirect", 32'(fetch_redirect), 32'd0);
      chk("rst_meta", 32'(execute_bpredictor_meta), 32'd0);
      reset = 1'b1;
      step();

      // Not-taken prediction, actually taken: counter 0 -> 1 in slot 0, redirect to target.
      push_in(32'h100, 1'b0, 32'h104, 24'h500012);
      step();
      exec_in(1'b1, 1'b1, 32'h200);
      step();
      chk("t1_update", 32'(execute_bpredictor_update), 32'd1);
      chk("t1_miss", 32'(execute_bpredictor_miss), 32'd1);
      chk("t1_meta", 32'(execute_bpredictor_meta), 32'h510112);
      chk("t1_redirect", 32'(fetch_redirect), 32'd1);
      chk("t1_redirect_pc", fetch_redirect_PC, 32'h200);
      step();

      // Correct taken prediction with a saturated counter in slot 2.
      push_in(32'h48, 1'b1, 32'h40, 24'h303022);
      step();
      exec_in(1'b1, 1'b1, 32'h40);
      step();
      chk("t2_update", 32'(execute_bpredictor_update), 32'd1);
      chk("t2_miss", 32'(execute_bpredictor_miss), 32'd0);
      chk("t2_meta", 32'(execute_bpredictor_meta), 32'h313022);
      chk("t2_redirect", 32'(fetch_redirect), 32'd0);

      // Target mismatch: flush drops the younger entry and pushes in the miss and flush cycles.
      push_in(32'h7C, 1'b1, 32'h80, 24'h904033);
      step();
      push_in(32'h80, 1'b0, 32'h84, 24'h000000);
      step();
      exec_in(1'b1, 1'b1, 32'h84);
      push_in(32'h90, 1'b0, 32'h94, 24'h000000);
      step();
      chk("t3_redirect_pc", fetch_redirect_PC, 32'h84);
      chk("t3_meta", 32'(execute_bpredictor_meta), 32'h988033);
      push_in(32'hA0, 1'b1, 32'hA4, 24'h000000);
      step();
      push_in(32'hB0, 1'b1, 32'hB4, 24'h000000);
      step();
      exec_in(1'b1, 1'b1, 32'hB4);
      step();
      chk("t3_next_pc", execute_bpredictor_PC, 32'hB0);
      chk("t3_next_miss", 32'(execute_bpredictor_miss), 32'd0);

      // Fill to full, then push and pop together; drain checks the order.
      for (int i = 0; i < 8; i++) begin
         push_in(32'h1000 + 32'(i * 4), 1'b0, 32'h0, {4'(i), 4'h0, 8'h55, 8'(i)});
         step();
      end
      chk("t4_full", 32'(resolve_full), 32'd1);
      push_in(32'h2000, 1'b0, 32'h0, 24'hF0AA77);
      exec_in(1'b1, 1'b0, 32'h0);
      step();
      chk("t4_full_kept", 32'(resolve_full), 32'd1);
      chk("t4_first_pc", execute_bpredictor_PC, 32'h1000);
      chk("t4_first_meta", 32'(execute_bpredictor_meta), 32'h015400);
      for (int i = 1; i < 8; i++) begin
         exec_in(1'b1, 1'b0, 32'h0);
         step();
      end
      chk("t4_last_pc", execute_bpredictor_PC, 32'h101C);
      exec_in(1'b0, 1'b0, 32'h0);
      step();
      chk("t4_nonbranch_update", 32'(execute_bpredictor_update), 32'd0);
      chk("t4_nonbranch_redirect", 32'(fetch_redirect), 32'd0);

      // Resolve with nothing in flight.
      exec_in(1'b1, 1'b1, 32'h500);
      step();
      chk("t5_underflow", 32'(resolve_underflow), 32'd1);
      chk("t5_update", 32'(execute_bpredictor_update), 32'd0);
      step();
      step();
      chk("t5_underflow_sticky", 32'(resolve_underflow), 32'd1);

      // Reset asserted while the redirect pulse is active.
      push_in(32'h300, 1'b0, 32'h304, 24'h000000);
      step();
      exec_in(1'b1, 1'b1, 32'h400);
      step();
      chk("t6_redirect", 32'(fetch_redirect), 32'd1);
      reset = 1'b0;
      #1;
      model_reset();
      chk("t6_redirect_dropped", 32'(fetch_redirect), 32'd0);
      chk("t6_underflow_cleared", 32'(resolve_underflow), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      step();
      push_in(32'h600, 1'b1, 32'h700, 24'h000000);
      step();
      exec_in(1'b1, 1'b1, 32'h700);
      step();
      chk("t6_after_reset_pc", execute_bpredictor_PC, 32'h600);
      step();

      check_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
